// File: rtl/khazad_cbc_ctrl_if.sv
// Streaming block interface between the AXI-side buffers and the KHAZAD sequencer.
// The master feeds input blocks and consumes results; the slave is the sequencer.
interface khazad_cbc_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/khazad_cbc_ctrl.sv
// Sequencer driving one KHAZAD core with ECB/CBC chaining in both directions.
// Holds key, IV and chaining value; captures the core result after last_round.
module khazad_cbc_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 7
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 cfg_load,
    input  logic [127:0]         cfg_key,
    input  logic [63:0]          cfg_iv,
    input  logic                 cfg_enc,
    input  logic                 cfg_cbc,
    output logic                 cfg_reject,
    khazad_cbc_ctrl_if.slave     strm,
    output logic                 busy,
    output logic                 timeout,
    output logic [63:0]          core_data_in,
    output logic [127:0]         core_key,
    output logic                 core_enc,
    output logic                 core_start,
    output logic                 core_only_data,
    input  logic [63:0]          core_data_out,
    input  logic                 core_last_round
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_CAPTURE,
        ST_OUTPUT
    } state_t;

    state_t         state_reg;
    logic [127:0]   key_reg;
    logic [63:0]    iv_reg;
    logic [63:0]    chain_reg;
    logic           enc_reg;
    logic           cbc_reg;
    logic           key_fresh_reg;
    logic [63:0]    in_reg;
    logic           last_reg;
    logic [TO_W-1:0] wd_reg;

    // A cfg_load coinciding with an accepted block must already govern that block.
    logic [127:0]   eff_key;
    logic [63:0]    eff_chain;
    logic           eff_enc;
    logic           eff_cbc;
    logic           eff_fresh;
    logic [63:0]    result;
    logic           in_ready_int;

    always_comb begin
        eff_key   = cfg_load ? cfg_key : key_reg;
        eff_chain = cfg_load ? cfg_iv  : chain_reg;
        eff_enc   = cfg_load ? cfg_enc : enc_reg;
        eff_cbc   = cfg_load ? cfg_cbc : cbc_reg;
        eff_fresh = cfg_load ? 1'b1    : key_fresh_reg;
        result    = (cbc_reg && !enc_reg) ? (core_data_out ^ chain_reg) : core_data_out;
    end

    assign in_ready_int  = (state_reg == ST_IDLE) && !strm.out_valid;
    assign strm.in_ready = in_ready_int;
    assign busy          = (state_reg != ST_IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg      <= ST_IDLE;
            key_reg        <= '0;
            iv_reg         <= '0;
            chain_reg      <= '0;
            enc_reg        <= 1'b1;
            cbc_reg        <= 1'b0;
            key_fresh_reg  <= 1'b1;
            in_reg         <= '0;
            last_reg       <= 1'b0;
            wd_reg         <= '0;
            cfg_reject     <= 1'b0;
            timeout        <= 1'b0;
            strm.out_valid <= 1'b0;
            strm.out_data  <= '0;
            strm.out_last  <= 1'b0;
            core_data_in   <= '0;
            core_key       <= '0;
            core_enc       <= 1'b0;
            core_start     <= 1'b0;
            core_only_data <= 1'b0;
        end else begin
            cfg_reject <= cfg_load && (state_reg != ST_IDLE);
            case (state_reg)
                ST_IDLE: begin
                    if (cfg_load) begin
                        key_reg       <= cfg_key;
                        iv_reg        <= cfg_iv;
                        chain_reg     <= cfg_iv;
                        enc_reg       <= cfg_enc;
                        cbc_reg       <= cfg_cbc;
                        key_fresh_reg <= 1'b1;
                        timeout       <= 1'b0;
                    end
                    if (strm.in_valid && in_ready_int) begin
                        in_reg         <= strm.in_data;
                        last_reg       <= strm.in_last;
                        core_start     <= 1'b1;
                        core_only_data <= !eff_fresh;
                        core_enc       <= eff_enc;
                        core_key       <= eff_key;
                        core_data_in   <= (eff_cbc && eff_enc) ? (strm.in_data ^ eff_chain)
                                                               : strm.in_data;
                        state_reg      <= ST_START;
                    end
                end
                ST_START: begin
                    core_start    <= 1'b0;
                    key_fresh_reg <= 1'b0;
                    wd_reg        <= '0;
                    state_reg     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_last_round) begin
                        state_reg <= ST_CAPTURE;
                    end else if (wd_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout   <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        wd_reg <= wd_reg + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    strm.out_data  <= result;
                    strm.out_last  <= last_reg;
                    strm.out_valid <= 1'b1;
                    // End of message rewinds the chain so the next message restarts from the IV.
                    if (last_reg)
                        chain_reg <= iv_reg;
                    else if (cbc_reg)
                        chain_reg <= enc_reg ? core_data_out : in_reg;
                    state_reg <= ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (strm.out_ready) begin
                        strm.out_valid <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_khazad_cbc_ctrl.sv
// Self-checking bench for khazad_cbc_ctrl with a stub core (data_out = data_in ^ key[63:0]).
// A message-level ECB/CBC reference model predicts every core input and output block.
module tb_khazad_cbc_ctrl;

    logic         CLK = 1'b0;
    logic         RST;
    logic         cfg_load = 1'b0;
    logic [127:0] cfg_key = '0;
    logic [63:0]  cfg_iv = '0;
    logic         cfg_enc = 1'b0;
    logic         cfg_cbc = 1'b0;
    logic         cfg_reject;
    logic         busy;
    logic         timeout;
    logic [63:0]  core_data_in;
    logic [127:0] core_key;
    logic         core_enc;
    logic         core_start;
    logic         core_only_data;
    logic [63:0]  core_data_out = '0;
    logic         core_last_round;

    khazad_cbc_ctrl_if strm ();

    khazad_cbc_ctrl #(.TIMEOUT_CYCLES(64), .TO_W(7)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .cfg_load       (cfg_load),
        .cfg_key        (cfg_key),
        .cfg_iv         (cfg_iv),
        .cfg_enc        (cfg_enc),
        .cfg_cbc        (cfg_cbc),
        .cfg_reject     (cfg_reject),
        .strm           (strm.slave),
        .busy           (busy),
        .timeout        (timeout),
        .core_data_in   (core_data_in),
        .core_key       (core_key),
        .core_enc       (core_enc),
        .core_start     (core_start),
        .core_only_data (core_only_data),
        .core_data_out  (core_data_out),
        .core_last_round(core_last_round)
    );

    always #5 CLK = ~CLK;

    // Stub core: result latched when start is seen, last_round pulses nine edges later.
    logic stub_dead = 1'b0;
    logic stub_run  = 1'b0;
    int   stub_cnt  = 0;
    always @(posedge CLK) begin
        if (core_start) begin
            stub_run      <= 1'b1;
            stub_cnt      <= 1;
            core_data_out <= core_data_in ^ core_key[63:0];
        end else if (stub_run) begin
            if (stub_cnt == 9) begin
                stub_run <= 1'b0;
                stub_cnt <= 0;
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end
    assign core_last_round = stub_run && (stub_cnt == 9) && !stub_dead;

    int total = 0;
    int bad   = 0;

    // Reference model state (what the controller should hold)
    logic [127:0] m_key;
    logic [63:0]  m_iv, m_chain;
    bit           m_enc, m_cbc, m_fresh;
    // Pending configuration for the next load
    logic [127:0] p_key;
    logic [63:0]  p_iv;
    bit           p_enc, p_cbc;

    logic [63:0]  c1, c2, y;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] cipher(input logic [63:0] x);
        return x ^ m_key[63:0];
    endfunction

    task automatic model_reset();
        m_key = '0; m_iv = '0; m_chain = '0; m_enc = 1; m_cbc = 0; m_fresh = 1;
    endtask

    task automatic model_cfg();
        m_key = p_key; m_iv = p_iv; m_chain = p_iv; m_enc = p_enc; m_cbc = p_cbc; m_fresh = 1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_reject"}, cfg_reject, 0);
        chk({tag, "_ovalid"}, strm.out_valid, 0);
        chk({tag, "_odata"}, strm.out_data, 0);
        chk({tag, "_olast"}, strm.out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_cdin"}, core_data_in, 0);
        chk({tag, "_ckey"}, core_key, 0);
        chk({tag, "_cenc"}, core_enc, 0);
        chk({tag, "_cstart"}, core_start, 0);
        chk({tag, "_conly"}, core_only_data, 0);
        chk({tag, "_iready"}, strm.in_ready, 1);
    endtask

    task automatic do_cfg();
        cfg_key = p_key; cfg_iv = p_iv; cfg_enc = p_enc; cfg_cbc = p_cbc; cfg_load = 1'b1;
        @(posedge CLK); #1;
        cfg_load = 1'b0;
        model_cfg();
        chk("cfg_reject_idle", cfg_reject, 0);
        chk("cfg_timeout_clr", timeout, 0);
        chk("cfg_busy", busy, 0);
    endtask

    // Present one block, wait (bounded) for acceptance; leaves time at accept edge + 1.
    task automatic accept(input logic [63:0] x, input bit last);
        bit got, ok;
        ok = 0;
        strm.in_valid = 1'b1; strm.in_data = x; strm.in_last = last;
        for (int k = 0; k < 50; k++) begin
            got = strm.in_ready;
            @(posedge CLK); #1;
            cfg_load = 1'b0;
            if (got) begin ok = 1; break; end
        end
        strm.in_valid = 1'b0;
        chk("accept", ok, 1);
    endtask

    task automatic run_block(input logic [63:0] x, input bit last, input int hold,
                             input bit with_cfg, output logic [63:0] yo);
        logic [63:0] exp_din;
        bit exp_od;
        int k;
        if (with_cfg) begin
            cfg_key = p_key; cfg_iv = p_iv; cfg_enc = p_enc; cfg_cbc = p_cbc; cfg_load = 1'b1;
            model_cfg();
        end
        exp_od = !m_fresh;
        if (!m_cbc) begin
            exp_din = x;
            yo = cipher(x);
        end else if (m_enc) begin
            exp_din = x ^ m_chain;
            yo = cipher(exp_din);
            m_chain = yo;
        end else begin
            exp_din = x;
            yo = cipher(x) ^ m_chain;
            m_chain = x;
        end
        if (last) m_chain = m_iv;
        m_fresh = 0;

        accept(x, last);
        chk("core_start", core_start, 1);
        chk("core_only_data", core_only_data, exp_od);
        chk("core_data_in", core_data_in, exp_din);
        chk("core_key", core_key, m_key);
        chk("core_enc", core_enc, m_enc);
        chk("busy_run", busy, 1);

        for (k = 1; k <= 100; k++) begin
            @(posedge CLK); #1;
            if (strm.out_valid) break;
        end
        chk("latency", k, 11);
        chk("out_data", strm.out_data, yo);
        chk("out_last", strm.out_last, last);
        chk("core_din_held", core_data_in, exp_din);

        for (int h = 0; h < hold; h++) begin
            cfg_load = (h == 3);
            cfg_key = ~m_key; cfg_iv = ~m_iv; cfg_enc = !m_enc; cfg_cbc = !m_cbc;
            @(posedge CLK); #1;
            cfg_load = 1'b0;
            chk("hold_data", strm.out_data, yo);
            chk("hold_valid", strm.out_valid, 1);
            chk("hold_in_ready", strm.in_ready, 0);
            if (h == 3) chk("cfg_reject", cfg_reject, 1);
            if (h == 4) chk("cfg_reject_pulse", cfg_reject, 0);
        end
        strm.out_ready = 1'b1;
        @(posedge CLK); #1;
        strm.out_ready = 1'b0;
        chk("out_valid_clr", strm.out_valid, 0);
        chk("in_ready_back", strm.in_ready, 1);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        strm.in_valid = 1'b0; strm.in_data = '0; strm.in_last = 1'b0; strm.out_ready = 1'b0;
        RST = 1'b1;
        #1 RST = 1'b0;
        #2;
        model_reset();
        chk_reset_outs("rst0");
        @(posedge CLK); #2 RST = 1'b1;
        @(posedge CLK); #1;

        // ECB encrypt, key fresh then reused
        p_key = 128'hFF; p_iv = '0; p_enc = 1; p_cbc = 0;
        do_cfg();
        run_block(64'h0123456789ABCDEF, 0, 0, 0, y);
        run_block({$urandom, $urandom}, 1, 0, 0, y);

        // CBC encrypt two zero blocks, then one more to show the chain rewound to the IV
        p_key = 128'hFF; p_iv = 64'h1111111111111111; p_enc = 1; p_cbc = 1;
        do_cfg();
        run_block(64'h0, 0, 0, 0, c1);
        run_block(64'h0, 1, 0, 0, c2);
        run_block(64'h0, 1, 0, 0, y);

        // CBC decrypt of the ciphertexts, with back-pressure and a rejected load on the first
        p_enc = 0;
        do_cfg();
        run_block(c1, 0, 20, 0, y);
        run_block(c2, 1, 0, 0, y);

        // Config load in the same cycle as an accepted block
        p_key = {$urandom, $urandom, $urandom, $urandom}; p_iv = {$urandom, $urandom};
        p_enc = 1; p_cbc = 1;
        run_block({$urandom, $urandom}, 0, 0, 1, y);
        run_block({$urandom, $urandom}, 1, 1, 0, y);

        // Random messages in random modes
        for (int m = 0; m < 10; m++) begin
            int len;
            bit wc;
            p_key = {$urandom, $urandom, $urandom, $urandom}; p_iv = {$urandom, $urandom};
            p_enc = $urandom_range(0, 1); p_cbc = $urandom_range(0, 1);
            len = $urandom_range(1, 3);
            wc = $urandom_range(0, 1);
            if (!wc) do_cfg();
            for (int b = 0; b < len; b++)
                run_block({$urandom, $urandom}, (b == len - 1), $urandom_range(0, 2), wc && (b == 0), y);
        end

        // Watchdog: the core never finishes
        stub_dead = 1'b1;
        accept({$urandom, $urandom}, 1);
        m_fresh = 0;
        for (int k = 1; k <= 65; k++) begin
            @(posedge CLK); #1;
            if (k == 64) begin
                chk("to_not_yet", timeout, 0);
                chk("to_busy_wait", busy, 1);
            end
        end
        chk("timeout_set", timeout, 1);
        chk("to_busy", busy, 0);
        chk("to_no_out", strm.out_valid, 0);
        chk("to_in_ready", strm.in_ready, 1);
        stub_dead = 1'b0;
        repeat (12) @(posedge CLK);
        #1;
        p_key = 128'hFF; p_iv = 64'h2222222222222222; p_enc = 1; p_cbc = 1;
        do_cfg();
        run_block(64'h5, 0, 0, 0, y);

        // Reset during WAIT, then a block issued with reset config and fresh key
        accept({$urandom, $urandom}, 0);
        repeat (4) @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        chk_reset_outs("rst_wait");
        repeat (12) @(posedge CLK);
        #1 RST = 1'b1;
        model_reset();
        run_block({$urandom, $urandom}, 1, 0, 0, y);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
